// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer driving a time_fsm timer, vehicle lamps,
// a pedestrian WALK lamp and a night flashing-yellow mode.
module traffic_phase_ctrl #(
    parameter int unsigned GREEN_NS_S = 20,
    parameter int unsigned GREEN_EW_S = 15,
    parameter int unsigned YELLOW_S   = 3,
    parameter int unsigned ALLRED_S   = 1,
    parameter int unsigned WALK_S     = 10,
    parameter int unsigned FLASH_S    = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic        ped_req,
    input  logic        night_mode,
    input  logic        finished,
    output logic        tmr_enable,
    output logic        tmr_reset,
    output logic [15:0] secondsToCount,
    output logic [2:0]  ns_lamp,
    output logic [2:0]  ew_lamp,
    output logic        walk,
    output logic [3:0]  phase
);

    typedef enum logic [3:0] {
        S_NS_G      = 4'd0,
        S_NS_Y      = 4'd1,
        S_AR1       = 4'd2,
        S_EW_G      = 4'd3,
        S_EW_Y      = 4'd4,
        S_AR2       = 4'd5,
        S_WALK      = 4'd6,
        S_NIGHT_ON  = 4'd7,
        S_NIGHT_OFF = 4'd8
    } state_t;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    localparam bit PARAMS_OK = (GREEN_NS_S != 0) && (GREEN_EW_S != 0) &&
                               (YELLOW_S != 0) && (ALLRED_S != 0) &&
                               (WALK_S != 0) && (FLASH_S != 0);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  blank;
    logic        ped_pending;
    logic        resume_ew;
    logic        advance;
    logic [2:0]  ns_nxt;
    logic [2:0]  ew_nxt;
    logic        walk_nxt;
    logic [15:0] secs_nxt;

    assign tmr_enable = enable;
    assign phase      = state;

    // finished from the timer is stale until two cycles into a phase
    assign advance = enable && finished && (blank == 2'd0);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= S_AR1;
            blank          <= 2'd2;
            ped_pending    <= 1'b0;
            resume_ew      <= 1'b0;
            tmr_reset      <= 1'b1;
            secondsToCount <= 16'(ALLRED_S);
            ns_lamp        <= L_RED;
            ew_lamp        <= L_RED;
            walk           <= 1'b0;
        end else begin
            tmr_reset <= 1'b0;
            if (enable && blank != 2'd0) begin
                blank <= blank - 2'd1;
            end
            if (advance) begin
                state          <= state_nxt;
                blank          <= 2'd2;
                tmr_reset      <= 1'b1;
                secondsToCount <= secs_nxt;
                ns_lamp        <= ns_nxt;
                ew_lamp        <= ew_nxt;
                walk           <= walk_nxt;
                if (state_nxt == S_WALK) begin
                    resume_ew <= (state == S_AR1);
                end
            end
            if (advance && state_nxt == S_WALK) begin
                ped_pending <= 1'b0;
            end else if (ped_req && state != S_WALK) begin
                ped_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_NS_G: state_nxt = S_NS_Y;
            S_NS_Y: state_nxt = S_AR1;
            S_AR1: begin
                if (night_mode) state_nxt = S_NIGHT_ON;
                else if (ped_pending) state_nxt = S_WALK;
                else state_nxt = S_EW_G;
            end
            S_EW_G: state_nxt = S_EW_Y;
            S_EW_Y: state_nxt = S_AR2;
            S_AR2: begin
                if (night_mode) state_nxt = S_NIGHT_ON;
                else if (ped_pending) state_nxt = S_WALK;
                else state_nxt = S_NS_G;
            end
            S_WALK:     state_nxt = resume_ew ? S_EW_G : S_NS_G;
            S_NIGHT_ON: state_nxt = S_NIGHT_OFF;
            S_NIGHT_OFF: begin
                state_nxt = night_mode ? S_NIGHT_ON : S_AR1;
            end
            default: state_nxt = S_AR1;
        endcase
    end

    always_comb begin
        ns_nxt   = L_RED;
        ew_nxt   = L_RED;
        walk_nxt = 1'b0;
        secs_nxt = 16'(ALLRED_S);
        unique case (state_nxt)
            S_NS_G: begin
                ns_nxt   = L_GRN;
                secs_nxt = 16'(GREEN_NS_S);
            end
            S_NS_Y: begin
                ns_nxt   = L_YEL;
                secs_nxt = 16'(YELLOW_S);
            end
            S_EW_G: begin
                ew_nxt   = L_GRN;
                secs_nxt = 16'(GREEN_EW_S);
            end
            S_EW_Y: begin
                ew_nxt   = L_YEL;
                secs_nxt = 16'(YELLOW_S);
            end
            S_WALK: begin
                walk_nxt = 1'b1;
                secs_nxt = 16'(WALK_S);
            end
            S_NIGHT_ON: begin
                ns_nxt   = L_YEL;
                ew_nxt   = L_YEL;
                secs_nxt = 16'(FLASH_S);
            end
            S_NIGHT_OFF: begin
                ns_nxt   = L_OFF;
                ew_nxt   = L_OFF;
                secs_nxt = 16'(FLASH_S);
            end
            default: secs_nxt = 16'(ALLRED_S);
        endcase
    end

    always @(posedge CLK) begin
        if (!reset) begin
            assert (PARAMS_OK)
                else $error("traffic_phase_ctrl: zero-length phase parameter");
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: behavioural timer, phase-level reference
// model compared every cycle, plus directed scenarios with literal checks.
module tb_traffic_phase_ctrl;

    localparam int TPS = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        enable;
    logic        ped_req;
    logic        night_mode;
    logic        finished = 1'b1;
    logic        tmr_enable;
    logic        tmr_reset;
    logic [15:0] secondsToCount;
    logic [2:0]  ns_lamp;
    logic [2:0]  ew_lamp;
    logic        walk;
    logic [3:0]  phase;

    int checks   = 0;
    int failures = 0;

    traffic_phase_ctrl #(
        .GREEN_NS_S(2), .GREEN_EW_S(2), .YELLOW_S(1),
        .ALLRED_S(1), .WALK_S(2), .FLASH_S(1)
    ) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .ped_req(ped_req),
        .night_mode(night_mode), .finished(finished),
        .tmr_enable(tmr_enable), .tmr_reset(tmr_reset),
        .secondsToCount(secondsToCount), .ns_lamp(ns_lamp),
        .ew_lamp(ew_lamp), .walk(walk), .phase(phase)
    );

    always #5 CLK = ~CLK;

    // time_fsm stand-in: TPS clocks per second, finished stays stale across its reset
    int t_cnt = 0;
    always @(posedge CLK) begin
        if (tmr_reset) begin
            t_cnt <= 0;
        end else if (tmr_enable) begin
            t_cnt    <= t_cnt + 1;
            finished <= (t_cnt + 1 >= int'(secondsToCount) * TPS);
        end
    end

    int ns_tab[9]  = '{1, 2, 4, 4, 4, 4, 4, 2, 0};
    int ew_tab[9]  = '{4, 4, 4, 1, 2, 4, 4, 2, 0};
    int dur_tab[9] = '{2, 1, 1, 2, 1, 1, 2, 1, 1};

    function automatic int succ(int p, bit night, bit ped, int from);
        case (p)
            0: return 1;
            1: return 2;
            2: return night ? 7 : (ped ? 6 : 3);
            3: return 4;
            4: return 5;
            5: return night ? 7 : (ped ? 6 : 0);
            6: return (from == 2) ? 3 : 0;
            7: return 8;
            8: return night ? 7 : 2;
            default: return 2;
        endcase
    endfunction

    int m_phase = 2;
    int m_age   = 0;
    int m_from  = 2;
    bit m_ped   = 1'b0;
    bit m_entry = 1'b1;
    bit m_valid = 1'b0;
    logic m_adv;
    int m_nxt;

    assign m_adv = enable && finished && (m_age >= 2);
    assign m_nxt = succ(m_phase, night_mode, m_ped, m_from);

    always @(posedge CLK) begin
        m_valid <= 1'b1;
        if (reset) begin
            m_phase <= 2;
            m_age   <= 0;
            m_ped   <= 1'b0;
            m_entry <= 1'b1;
        end else begin
            m_entry <= m_adv;
            if (m_adv) begin
                m_phase <= m_nxt;
                m_age   <= 0;
                if (m_nxt == 6) m_from <= m_phase;
            end else if (enable && m_age < 2) begin
                m_age <= m_age + 1;
            end
            if (m_adv && m_nxt == 6) m_ped <= 1'b0;
            else if (ped_req && m_phase != 6) m_ped <= 1'b1;
        end
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    int seq[$];
    int exp_q[$];
    int prev_phase = 99;
    int run = 0;
    int last_len = 0;

    always @(negedge CLK) begin
        #1;
        if (m_valid) begin
            chk("phase", int'(phase), m_phase);
            chk("ns_lamp", int'(ns_lamp), ns_tab[m_phase]);
            chk("ew_lamp", int'(ew_lamp), ew_tab[m_phase]);
            chk("walk", int'(walk), int'(m_phase == 6));
            chk("secs", int'(secondsToCount), dur_tab[m_phase]);
            chk("tmr_reset", int'(tmr_reset), int'(m_entry));
            chk("tmr_enable", int'(tmr_enable), int'(enable));
            chk("two_greens", int'(ns_lamp[0] & ew_lamp[0]), 0);
            if (int'(phase) != prev_phase) begin
                seq.push_back(int'(phase));
                last_len   = run;
                run        = 1;
                prev_phase = int'(phase);
            end else begin
                run++;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge CLK);
            #2;
        end
    endtask

    task automatic wait_phase(int p);
        int k = 0;
        while (int'(phase) != p && k < 200) begin
            @(negedge CLK);
            #2;
            k++;
        end
        if (int'(phase) != p) chk("wait_timeout", int'(phase), p);
    endtask

    task automatic check_seq(string nm);
        chk({nm, "_len"}, seq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seq.size(); i++) begin
            chk(nm, seq[i], exp_q[i]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        cyc(3);
        reset = 1'b0;
        chk("rst_phase", int'(phase), 2);
        chk("rst_tmr_reset", int'(tmr_reset), 1);
        chk("rst_secs", int'(secondsToCount), 1);
        chk("rst_ns", int'(ns_lamp), 4);
        chk("rst_ew", int'(ew_lamp), 4);
        chk("rst_walk", int'(walk), 0);
        cyc(1);
        chk("stale_hold1", int'(phase), 2);
        chk("stale_pulse", int'(tmr_reset), 0);
        cyc(1);
        chk("stale_hold2", int'(phase), 2);

        wait_phase(3);
        wait_phase(0);
        wait_phase(2);
        exp_q = '{2, 3, 4, 5, 0, 1, 2};
        check_seq("seq_full");

        seq.delete();
        wait_phase(0);
        cyc(2);
        ped_req = 1'b1;
        cyc(1);
        ped_req = 1'b0;
        wait_phase(6);
        chk("walk_on", int'(walk), 1);
        chk("walk_secs", int'(secondsToCount), 2);
        chk("walk_ns", int'(ns_lamp), 4);
        wait_phase(3);
        wait_phase(0);
        exp_q = '{3, 4, 5, 0, 1, 2, 6, 3, 4, 5, 0};
        check_seq("seq_ped");

        seq.delete();
        wait_phase(3);
        cyc(2);
        night_mode = 1'b1;
        ped_req    = 1'b1;
        cyc(1);
        ped_req = 1'b0;
        wait_phase(7);
        chk("night_on_ns", int'(ns_lamp), 2);
        chk("night_on_ew", int'(ew_lamp), 2);
        wait_phase(8);
        chk("night_off_ns", int'(ns_lamp), 0);
        chk("night_off_ew", int'(ew_lamp), 0);
        chk("flash_len", last_len, 1 * TPS + 2);
        wait_phase(7);
        night_mode = 1'b0;
        wait_phase(8);
        wait_phase(2);
        wait_phase(6);
        wait_phase(3);
        exp_q = '{1, 2, 3, 4, 5, 7, 8, 7, 8, 2, 6, 3};
        check_seq("seq_night");

        wait_phase(0);
        cyc(3);
        enable = 1'b0;
        cyc(1);
        chk("pause_tmr_en", int'(tmr_enable), 0);
        cyc(19);
        chk("pause_phase", int'(phase), 0);
        chk("pause_ns", int'(ns_lamp), 1);
        enable = 1'b1;
        wait_phase(1);
        chk("paused_green_len", last_len, 2 * TPS + 2 + 20);

        wait_phase(4);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_phase", int'(phase), 2);
        chk("mid_rst_ns", int'(ns_lamp), 4);
        chk("mid_rst_ew", int'(ew_lamp), 4);
        chk("mid_rst_walk", int'(walk), 0);
        chk("mid_rst_pulse", int'(tmr_reset), 1);
        chk("mid_rst_secs", int'(secondsToCount), 1);
        wait_phase(3);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
